// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between spi_slave and the LED frame datapath: parses one command frame
// per chip-select assertion into RAM writes, config updates or config readback on MISO.
module spi_cmd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_byte_vld_i,
  input  logic [7:0]            spi_byte_data_i,
  output logic [7:0]            spi_byte_data_o,
  input  logic                  frame_busy_i,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [7:0]            ram_wr_data_o,
  output logic [31:0]           conf_data_o,
  output logic                  frame_start_o,
  output logic [ADDR_WIDTH:0]   frame_len_o
);

  localparam logic [7:0] CmdConfWr = 8'h2A;
  localparam logic [7:0] CmdDataWr = 8'h2B;
  localparam logic [7:0] CmdInfoRd = 8'h2C;
  localparam logic [ADDR_WIDTH:0] CntMax = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [31:0] ConfReset = 32'h0F20_200F;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StConfWr,
    StDataWr,
    StInfoRd,
    StSkip
  } state_e;

  state_e                state_q;
  logic                  cs_q;
  logic                  cs_armed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [2:0]            conf_idx_q;
  logic [2:0]            info_idx_q;

  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH:0]   cnt_next;

  // Byte count including a byte that arrives in the same cycle as CS rise.
  always_comb begin
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    cnt_next = spi_byte_vld_i ? cnt_inc : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      cs_q            <= 1'b1;
      cs_armed_q      <= 1'b0;
      addr_q          <= '0;
      cnt_q           <= '0;
      conf_idx_q      <= '0;
      info_idx_q      <= '0;
      ram_wr_en_o     <= 1'b0;
      ram_wr_addr_o   <= '0;
      ram_wr_data_o   <= 8'h00;
      conf_data_o     <= ConfReset;
      frame_start_o   <= 1'b0;
      frame_len_o     <= '0;
      spi_byte_data_o <= 8'h00;
    end else begin
      cs_q          <= spi_cs_n_i;
      ram_wr_en_o   <= 1'b0;
      frame_start_o <= 1'b0;
      // After reset a frame only starts once CS has been seen high, so a frame cut by
      // reset is ignored until CS toggles.
      if (spi_cs_n_i) begin
        cs_armed_q <= 1'b1;
      end

      if (spi_byte_vld_i) begin
        unique case (state_q)
          StCmd: begin
            unique case (spi_byte_data_i)
              CmdConfWr: begin
                state_q    <= StConfWr;
                conf_idx_q <= '0;
              end
              CmdDataWr: begin
                state_q <= frame_busy_i ? StSkip : StDataWr;
                addr_q  <= '0;
                cnt_q   <= '0;
              end
              CmdInfoRd: begin
                state_q         <= StInfoRd;
                spi_byte_data_o <= conf_data_o[7:0];
                info_idx_q      <= 3'd1;
              end
              default: state_q <= StSkip;
            endcase
          end
          StConfWr: begin
            if (!conf_idx_q[2]) begin
              conf_data_o[{conf_idx_q[1:0], 3'b000} +: 8] <= spi_byte_data_i;
              conf_idx_q <= conf_idx_q + 1'b1;
            end
          end
          StDataWr: begin
            ram_wr_en_o   <= 1'b1;
            ram_wr_addr_o <= addr_q;
            ram_wr_data_o <= spi_byte_data_i;
            addr_q        <= addr_q + 1'b1;
            cnt_q         <= cnt_next;
          end
          StInfoRd: begin
            if (!info_idx_q[2]) begin
              spi_byte_data_o <= conf_data_o[{info_idx_q[1:0], 3'b000} +: 8];
              info_idx_q      <= info_idx_q + 1'b1;
            end else begin
              spi_byte_data_o <= 8'h00;
            end
          end
          default: ;
        endcase
      end

      // CS high ends the frame; these assignments take priority over the byte handling.
      if (spi_cs_n_i) begin
        state_q         <= StIdle;
        spi_byte_data_o <= 8'h00;
        if (state_q == StDataWr && cnt_next != '0) begin
          frame_len_o   <= cnt_next;
          frame_start_o <= 1'b1;
        end
      end else if (state_q == StIdle && cs_q && cs_armed_q) begin
        state_q <= StCmd;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: frame-level behavioural model compared every cycle, plus
// literal expectations from hand-worked scenarios.
module tb_spi_cmd_ctrl;
  localparam int unsigned AW = 2;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          vld = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          busy = 1'b0;
  logic [7:0]    miso;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [31:0]   conf;
  logic          fstart;
  logic [AW:0]   flen;

  spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spi_cs_n_i     (cs_n),
    .spi_byte_vld_i (vld),
    .spi_byte_data_i(din),
    .spi_byte_data_o(miso),
    .frame_busy_i   (busy),
    .ram_wr_en_o    (wr_en),
    .ram_wr_addr_o  (wr_addr),
    .ram_wr_data_o  (wr_data),
    .conf_data_o    (conf),
    .frame_start_o  (fstart),
    .frame_len_o    (flen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  logic [7:0] m_conf[4] = '{8'h0F, 8'h20, 8'h20, 8'h0F};
  bit         m_active = 0, m_have_cmd = 0, m_rej = 0, m_armed = 0, m_prev_cs = 1;
  logic [7:0] m_cmd = 8'h00;
  int         m_nbytes = 0;
  bit         exp_wr_en = 0, exp_start = 0;
  int         exp_addr = 0, exp_len = 0;
  logic [7:0] exp_data = 8'h00, exp_miso = 8'h00;

  // Observation logs for literal checks
  int         wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  logic [7:0] miso_log[$];
  int         start_cnt = 0;
  bit         busy_lvl = 0;
  logic [7:0] tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(bit r, bit cs, bit v, logic [7:0] d, bit b);
    int k;
    if (r) begin
      m_conf = '{8'h0F, 8'h20, 8'h20, 8'h0F};
      exp_wr_en = 0; exp_start = 0; exp_addr = 0; exp_len = 0;
      exp_data = 8'h00; exp_miso = 8'h00;
      m_active = 0; m_have_cmd = 0; m_armed = 0; m_prev_cs = 1;
      return;
    end
    exp_wr_en = 0;
    exp_start = 0;
    if (m_active && v) begin
      if (!m_have_cmd) begin
        m_have_cmd = 1; m_cmd = d; m_nbytes = 0;
        m_rej = (d == 8'h2B) && b;
        if (d == 8'h2C) exp_miso = m_conf[0];
      end else begin
        if (m_cmd == 8'h2A && m_nbytes < 4) m_conf[m_nbytes] = d;
        if (m_cmd == 8'h2B && !m_rej) begin
          exp_wr_en = 1; exp_addr = m_nbytes % Depth; exp_data = d;
        end
        if (m_cmd == 8'h2C) begin
          k = m_nbytes + 1;
          exp_miso = (k < 4) ? m_conf[k] : 8'h00;
        end
        m_nbytes++;
      end
    end
    if (cs) begin
      if (m_active && m_have_cmd && m_cmd == 8'h2B && !m_rej && m_nbytes > 0) begin
        exp_len = (m_nbytes > Depth) ? Depth : m_nbytes;
        exp_start = 1;
      end
      m_active = 0;
      exp_miso = 8'h00;
      m_armed = 1;
    end else if (!m_active && m_armed && m_prev_cs) begin
      m_active = 1;
      m_have_cmd = 0;
    end
    m_prev_cs = cs;
  endfunction

  task automatic compare_all();
    chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
    chk("wr_data", 32'(wr_data), 32'(exp_data));
    chk("conf", conf, {m_conf[3], m_conf[2], m_conf[1], m_conf[0]});
    chk("miso", 32'(miso), 32'(exp_miso));
    chk("frame_start", 32'(fstart), 32'(exp_start));
    chk("frame_len", 32'(flen), 32'(exp_len));
  endtask

  task automatic cycle(input bit r, input bit cs, input bit v, input logic [7:0] d);
    rst = r; cs_n = cs; vld = v; din = d; busy = busy_lvl;
    @(posedge clk);
    model_step(r, cs, v, d, busy_lvl);
    #1;
    compare_all();
    if (wr_en) begin
      wr_addr_log.push_back(int'(wr_addr));
      wr_data_log.push_back(wr_data);
    end
    if (fstart) start_cnt++;
    if (v) miso_log.push_back(miso);
  endtask

  task automatic send(input logic [7:0] d);
    cycle(0, 0, 1, d);
    repeat (3) cycle(0, 0, 0, 8'h00);
  endtask

  task automatic cs_low();
    repeat (2) cycle(0, 0, 0, 8'h00);
  endtask

  task automatic cs_high();
    repeat (3) cycle(0, 1, 0, 8'h00);
  endtask

  task automatic run_frame();
    cs_low();
    foreach (tx[i]) send(tx[i]);
    cs_high();
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    miso_log.delete();
    start_cnt = 0;
  endtask

  int         exp_a[6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0] exp_m[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};

  initial begin
    repeat (2) cycle(1, 1, 0, 8'h00);
    cs_high();
    chk("reset_conf", conf, 32'h0F20_200F);
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_len", 32'(flen), 32'h0);

    // Config write, extra byte ignored
    clear_logs();
    tx = '{8'h2A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame();
    chk("confwr_value", conf, 32'h4433_2211);
    chk("confwr_no_writes", wr_addr_log.size(), 0);
    chk("confwr_no_start", start_cnt, 0);

    // Config readback
    clear_logs();
    tx = '{8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame();
    chk("info_count", miso_log.size(), 6);
    for (int i = 0; i < 6 && i < miso_log.size(); i++) chk("info_byte", 32'(miso_log[i]),
                                                           32'(exp_m[i]));
    chk("info_after_cs", 32'(miso), 32'h0);

    // Pixel write with address wrap and saturated count
    clear_logs();
    tx = '{8'h2B, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame();
    chk("wrap_count", wr_addr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_addr_log.size(); i++) begin
      chk("wrap_addr", wr_addr_log[i], exp_a[i]);
      chk("wrap_data", 32'(wr_data_log[i]), 32'(8'hA0 + i));
    end
    chk("wrap_starts", start_cnt, 1);
    chk("wrap_len", 32'(flen), 32'd4);

    // Last byte coincident with CS rise
    clear_logs();
    cs_low();
    send(8'h2B);
    send(8'h01);
    cycle(0, 1, 1, 8'h02);
    cs_high();
    chk("coin_writes", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) begin
      chk("coin_addr1", wr_addr_log[1], 1);
      chk("coin_data1", 32'(wr_data_log[1]), 32'h02);
    end
    chk("coin_len", 32'(flen), 32'd2);
    chk("coin_starts", start_cnt, 1);

    // Busy at decode rejects the frame
    clear_logs();
    busy_lvl = 1;
    tx = '{8'h2B, 8'h05, 8'h06};
    run_frame();
    busy_lvl = 0;
    chk("busy_no_writes", wr_addr_log.size(), 0);
    chk("busy_no_start", start_cnt, 0);
    chk("busy_len_kept", 32'(flen), 32'd2);

    // Unknown command skips the rest of the frame
    tx = '{8'h7F, 8'h2A, 8'h99};
    run_frame();
    chk("unknown_conf", conf, 32'h4433_2211);

    // Empty data frame
    clear_logs();
    tx = '{8'h2B};
    run_frame();
    chk("empty_no_start", start_cnt, 0);
    chk("empty_len_kept", 32'(flen), 32'd2);

    // Reset mid-frame with CS held low
    cs_low();
    send(8'h2B);
    send(8'h01);
    cycle(1, 0, 0, 8'h00);
    clear_logs();
    send(8'h2B);
    send(8'h10);
    send(8'h20);
    chk("rst_no_writes", wr_addr_log.size(), 0);
    chk("rst_conf", conf, 32'h0F20_200F);
    cs_high();
    tx = '{8'h2B, 8'h77};
    run_frame();
    chk("rst_restart_count", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) chk("rst_restart_addr", wr_addr_log[0], 0);
    chk("rst_restart_len", 32'(flen), 32'd1);
    chk("rst_restart_start", start_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer between `spi_slave` and the LED frame datapath. It parses the byte stream delivered by `spi_slave` into command frames, one frame per chip-select assertion. Depending on the command byte it:
- writes pixel bytes into the frame RAM,
- updates the LED timing configuration registers, or
- returns configuration bytes on MISO.

On completion of a pixel frame it issues a refresh request to the LED driver.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, frame RAM address width; RAM depth = 2^ADDR_WIDTH bytes.

Ports:
- `clk_i` in 1: system clock; everything is synchronous to it.
- `rst_i` in 1: one clock domain, synchronous active-high reset.
- `spi_cs_n_i` in 1: chip select, already synchronized to `clk_i`; low = frame active.
- `spi_byte_vld_i` in 1: one-cycle pulse from `spi_slave`, a received byte is valid.
- `spi_byte_data_i` in 8: received byte.
- `spi_byte_data_o` in→out 8: next byte to shift out on MISO; drives `spi_slave.spi_byte_data_i`.
- `frame_busy_i` in 1: LED driver is currently streaming the RAM.
- `ram_wr_en_o` out 1: frame RAM write strobe.
- `ram_wr_addr_o` out ADDR_WIDTH: write address.
- `ram_wr_data_o` out 8: write data.
- `conf_data_o` out 32: timing config; register k occupies bits [8k+7:8k].
- `frame_start_o` out 1: one-cycle refresh request.
- `frame_len_o` out ADDR_WIDTH+1: byte count of the last completed pixel frame.

## Operation
- **Commands** (first byte after CS falls):
  - 0x2A CONF_WR: following bytes go to config registers 0,1,2,3 in order; bytes beyond the 4th are ignored.
  - 0x2B DATA_WR: following bytes are written to RAM starting at address 0.
  - 0x2C INFO_RD: MISO returns config registers 0..3, then 0x00.
  - Any other value: the rest of the frame is ignored.
- **States:** IDLE, CMD, CONF_WR, DATA_WR, INFO_RD, SKIP.
  - IDLE → CMD on CS falling edge (previous sample high, current sample low). A low CS level alone does not enter CMD.
  - CMD on `spi_byte_vld_i` → CONF_WR / DATA_WR / INFO_RD / SKIP according to the command byte.
  - 0x2B with `frame_busy_i`=1 at decode goes to SKIP: no RAM writes and no `frame_start_o`.
  - Any state → IDLE when CS is sampled high.
- **DATA_WR:**
  - Each byte produces one write; the address increments after each write and wraps from 2^ADDR_WIDTH−1 to 0.
  - The byte counter saturates at 2^ADDR_WIDTH.
  - On CS rise with count ≥1: `frame_len_o` is loaded with the count and `frame_start_o` pulses. With count = 0: no pulse and `frame_len_o` is unchanged.
- **INFO_RD:**
  - On decode of 0x2C, `spi_byte_data_o` is loaded with config register 0.
  - Each later `spi_byte_vld_i` loads the next register; after register 3 it loads 0x00.
- **CS rise:** `spi_byte_data_o` returns to 0x00 in every state.
- **Simultaneous `spi_byte_vld_i` and CS rise in one cycle:** the byte is processed first (written or counted), then the block goes to IDLE. The frame length includes that byte.
- **Reset values:**
  - `ram_wr_en_o`=0, `ram_wr_addr_o`=0, `ram_wr_data_o`=0.
  - `conf_data_o`=32'h0F20_200F.
  - `frame_start_o`=0, `frame_len_o`=0, `spi_byte_data_o`=0x00.
  - State = IDLE; the internal CS history register resets to 1.
- **Reset asserted mid-frame:** all state is cleared. Bytes arriving while CS stays low are ignored until CS goes high and falls again.

## Timing
- **RAM write:** `ram_wr_en_o`, address and data are registered and valid exactly 1 cycle after `spi_byte_vld_i`. Writes are never back-to-back faster than the `spi_byte_vld_i` rate.
- **Config update:** `conf_data_o` reflects a CONF_WR byte 1 cycle after its `spi_byte_vld_i`.
- **MISO byte:** `spi_byte_data_o` updates 1 cycle after `spi_byte_vld_i`. This is required so `spi_slave` latches it before the next byte's first SCLK edge (≥8 SCLK periods per byte, SCLK ≤ clk_i/4).
- **Refresh request:** `frame_start_o` is high for exactly 1 cycle, in the cycle after CS is first sampled high. `frame_len_o` is valid in the same cycle and holds until the next completed DATA_WR frame.
- **`frame_busy_i`:** sampled only at command decode. Changes during DATA_WR do not abort the frame.

## Test plan
- **Config write:** CS low; bytes 0x2A,0x11,0x22,0x33,0x44,0x55; CS high → `conf_data_o`=32'h4433_2211; no RAM writes; no `frame_start_o`.
- **Config readback:** CS low; 0x2C then 5 dummy bytes → `spi_byte_data_o` sequence after each vld is 0x11,0x22,0x33,0x44,0x00,0x00; after CS high it is 0x00.
- **Pixel write with wrap:** ADDR_WIDTH=2; 0x2B then 6 bytes 0xA0..0xA5 → writes at addresses 0,1,2,3,0,1; after CS high one `frame_start_o` pulse with `frame_len_o`=4 (saturated).
- **Last byte coincident with CS rise:** 0x2B, 0x01, 0x02, with the vld of 0x02 in the same cycle as CS rise → both bytes written; `frame_len_o`=2; single `frame_start_o`.
- **Busy reject and unknown command:**
  - 0x2B with `frame_busy_i`=1 → no writes, no `frame_start_o`.
  - 0x7F followed by 0x2A, 0x99 → `conf_data_o` unchanged.
  - 0x2B followed by zero data bytes → no `frame_start_o`.
- **Reset mid-frame:** `rst_i` for 1 cycle during DATA_WR with CS held low, then 3 more bytes → no writes; `conf_data_o`=32'h0F20_200F. After CS high and a new 0x2B frame, writes restart at address 0.
